// File: rtl/count_display_8digit_if.sv
// count_display_8digit_if: control/status bundle for the eight-digit counter display.
//   Value    [26:0] binary value to be converted (master -> slave)
//   Update          capture-and-convert request (master -> slave)
//   Busy            conversion in progress (slave -> master)
//   Done            one-cycle pulse when new digits take effect (slave -> master)
//   Overflow        last captured Value exceeded 99999999 (slave -> master)
interface count_display_8digit_if;
    logic [26:0] Value;
    logic        Update;
    logic        Busy;
    logic        Done;
    logic        Overflow;

    modport master (
        output Value,
        output Update,
        input  Busy,
        input  Done,
        input  Overflow
    );

    modport slave (
        input  Value,
        input  Update,
        output Busy,
        output Done,
        output Overflow
    );
endinterface

// File: rtl/count_display_8digit.sv
// count_display_8digit: converts a 27-bit binary value to eight BCD digits with a sequential
// double-dabble engine and drives a multiplexed, active-low, eight-digit seven-segment display.
//   i_Clock_100MHz  sole clock, rising edge
//   i_Clear         synchronous active-high reset; aborts any conversion
//   io_bus          Value/Update in, Busy/Done/Overflow out (slave modport)
//   o_Anode_n       active-low digit enables, bit 0 = rightmost digit
//   o_Segments_n    active-low cathodes {dp,g,f,e,d,c,b,a}
module count_display_8digit #(
    parameter int unsigned SCAN_DIV      = 100000,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic                         i_Clock_100MHz,
    input  logic                         i_Clear,
    count_display_8digit_if.slave        io_bus,
    output logic [7:0]                   o_Anode_n,
    output logic [7:0]                   o_Segments_n
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [4:0] LAST_STEP = 5'd26;

    typedef enum logic [0:0] {StIdle, StConv} state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic        w_capture;
    logic        w_finish;

    logic [26:0] r_shift;
    logic [31:0] r_bcd;
    logic [4:0]  r_iter;
    logic        r_overflow;
    logic        r_done;
    logic [31:0] r_digits;
    logic        r_dash;

    logic [31:0] w_bcd_adj;
    logic [31:0] w_bcd_step;

    logic [PW-1:0] r_presc;
    logic [2:0]    r_scan;
    logic [7:0]    r_anode_n;
    logic [7:0]    r_segments_n;

    logic [3:0]  w_digit;
    logic [7:0]  w_lead_zero;
    logic        w_blank;
    logic [6:0]  w_seg;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Conversion FSM
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_finish     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (io_bus.Update) begin
                    w_capture    = 1'b1;
                    w_state_next = StConv;
                end
            end
            StConv: begin
                if (r_iter == LAST_STEP) begin
                    w_finish     = 1'b1;
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // One double-dabble step: add 3 to every nibble >= 5, then shift left pulling in the next bit
    always_comb begin
        w_bcd_adj = '0;
        for (int i = 0; i < 8; i++) begin
            w_bcd_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ? r_bcd[4*i +: 4] + 4'd3
                                                              : r_bcd[4*i +: 4];
        end
        w_bcd_step = (w_bcd_adj << 1) | 32'(r_shift[26]);
    end

    always_ff @(posedge i_Clock_100MHz) begin
        if (i_Clear) begin
            r_state    <= StIdle;
            r_shift    <= '0;
            r_bcd      <= '0;
            r_iter     <= '0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
            r_digits   <= '0;
            r_dash     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_finish;
            if (w_capture) begin
                r_shift    <= io_bus.Value;
                r_bcd      <= '0;
                r_iter     <= '0;
                r_overflow <= (io_bus.Value > 27'd99999999);
            end else if (r_state == StConv) begin
                r_bcd   <= w_bcd_step;
                r_shift <= {r_shift[25:0], 1'b0};
                r_iter  <= r_iter + 5'd1;
            end
            // Old digits stay on display until the final step lands
            if (w_finish) begin
                r_digits <= w_bcd_step;
                r_dash   <= r_overflow;
            end
        end
    end

    assign io_bus.Busy     = (r_state == StConv);
    assign io_bus.Done     = r_done;
    assign io_bus.Overflow = r_overflow;

    // Display scan
    always_comb begin
        w_digit        = r_digits[{r_scan, 2'b00} +: 4];
        w_lead_zero    = '0;
        w_lead_zero[7] = (r_digits[31:28] == 4'd0);
        for (int i = 6; i >= 0; i--) begin
            w_lead_zero[i] = w_lead_zero[i+1] & (r_digits[4*i +: 4] == 4'd0);
        end
        // Digit 0 is never blanked so a zero value still shows '0'
        w_blank = BLANK_LEADING && !r_dash && (r_scan != 3'd0) && w_lead_zero[r_scan];
        if (r_dash) begin
            w_seg = 7'b0111111;
        end else if (w_blank) begin
            w_seg = 7'b1111111;
        end else begin
            w_seg = seg7(w_digit);
        end
    end

    always_ff @(posedge i_Clock_100MHz) begin
        if (i_Clear) begin
            r_presc      <= '0;
            r_scan       <= '0;
            r_anode_n    <= 8'b1111_1110;
            r_segments_n <= 8'b1100_0000;
        end else begin
            if (r_presc == PRESC_MAX) begin
                r_presc <= '0;
                r_scan  <= r_scan + 3'd1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
            r_anode_n    <= ~(8'b0000_0001 << r_scan);
            r_segments_n <= {1'b1, w_seg};
        end
    end

    assign o_Anode_n    = r_anode_n;
    assign o_Segments_n = r_segments_n;

endmodule

// File: tb/tb_count_display_8digit.sv
// tb_count_display_8digit: scoreboard bench. Expected display images are pushed at each capture
// and compared when Done pulses; a second instance with SCAN_DIV=4 exercises the scan timing.
module tb_count_display_8digit;

    typedef struct packed {
        logic [63:0] segs;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        clear;
    logic [7:0]  anode_n;
    logic [7:0]  seg_n;
    logic [7:0]  anode4_n;
    logic [7:0]  seg4_n;
    int          n_checks;
    int          n_pass;
    exp_t        sb[$];

    count_display_8digit_if bus  ();
    count_display_8digit_if bus4 ();

    count_display_8digit #(
        .SCAN_DIV      (2),
        .BLANK_LEADING (1'b1)
    ) dut (
        .i_Clock_100MHz (clk),
        .i_Clear        (clear),
        .io_bus         (bus),
        .o_Anode_n      (anode_n),
        .o_Segments_n   (seg_n)
    );

    count_display_8digit #(
        .SCAN_DIV      (4),
        .BLANK_LEADING (1'b1)
    ) dut4 (
        .i_Clock_100MHz (clk),
        .i_Clear        (clear),
        .io_bus         (bus4),
        .o_Anode_n      (anode4_n),
        .o_Segments_n   (seg4_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] seg_of(input int unsigned d);
        case (d)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            default: return 8'h90;
        endcase
    endfunction

    function automatic exp_t model(input int unsigned v);
        exp_t        m;
        int unsigned p;
        m.ovf  = (v > 99999999);
        m.segs = '0;
        p      = 1;
        for (int i = 0; i < 8; i++) begin
            if (m.ovf) begin
                m.segs[8*i +: 8] = 8'hBF;
            end else if (i > 0 && v < p) begin
                m.segs[8*i +: 8] = 8'hFF;
            end else begin
                m.segs[8*i +: 8] = seg_of((v / p) % 10);
            end
            p = p * 10;
        end
        return m;
    endfunction

    // Pulse Update for one edge and follow the conversion through Busy
    task automatic convert(input int unsigned v);
        int n;
        @(negedge clk);
        bus.Value  = 27'(v);
        bus.Update = 1'b1;
        @(posedge clk);
        sb.push_back(model(v));
        @(negedge clk);
        bus.Update = 1'b0;
        check_eq("ovf_after_capture", 64'(bus.Overflow), 64'(v > 99999999));
        n = 0;
        while (bus.Busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        check_eq("busy_cycles", 64'(n), 64'd27);
        repeat (22) @(negedge clk);
    endtask

    // Monitor: pop and compare whenever Done pulses
    initial begin : monitor
        exp_t        e;
        logic [63:0] shown;
        forever begin
            @(negedge clk);
            if (bus.Done) begin
                check_eq("sb_has_entry_at_done", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check_eq("ovf_at_done", 64'(bus.Overflow), 64'(e.ovf));
                    shown = '0;
                    @(posedge clk);
                    for (int c = 0; c < 18; c++) begin
                        @(negedge clk);
                        if (c == 0) check_eq("done_one_cycle", 64'(bus.Done), 64'd0);
                        for (int j = 0; j < 8; j++) begin
                            if (anode_n[j] == 1'b0) shown[8*j +: 8] = seg_n;
                        end
                    end
                    check_eq("display_digits", shown, e.segs);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        int          idx;
        int          n;
        int unsigned va;
        int unsigned vb;
        n_checks   = 0;
        n_pass     = 0;
        clear      = 1'b1;
        bus.Update = 1'b0;
        bus.Value  = '0;
        bus4.Update = 1'b0;
        bus4.Value  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        clear = 1'b0;

        // Reset state
        check_eq("rst_busy", 64'(bus.Busy), 64'd0);
        check_eq("rst_done", 64'(bus.Done), 64'd0);
        check_eq("rst_ovf", 64'(bus.Overflow), 64'd0);
        check_eq("rst_anode", 64'(anode_n), 64'hFE);
        check_eq("rst_segs", 64'(seg_n), 64'hC0);

        // Scan stepping with SCAN_DIV=4, outputs one cycle behind the index
        for (int k = 0; k <= 40; k++) begin
            if (k > 0) @(negedge clk);
            idx = (k == 0) ? 0 : ((k - 1) / 4) % 8;
            check_eq("scan4_anode", 64'(anode4_n), 64'(8'hFF ^ (8'h01 << idx)));
            check_eq("scan4_segs", 64'(seg4_n), (idx == 0) ? 64'hC0 : 64'hFF);
        end

        convert(12345678);
        convert(0);
        convert(305);
        convert(99999999);
        convert(100000000);
        convert(134217727);
        convert(1000);

        // Update during Busy is dropped; Value changes after capture are ignored
        @(negedge clk);
        bus.Value  = 27'd42;
        bus.Update = 1'b1;
        @(posedge clk);
        sb.push_back(model(42));
        @(negedge clk);
        bus.Update = 1'b0;
        bus.Value  = 27'd777;
        repeat (2) @(negedge clk);
        bus.Update = 1'b1;
        @(negedge clk);
        bus.Update = 1'b0;
        n = 0;
        while (bus.Busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        check_eq("drop_busy_cycles", 64'(n), 64'd24);
        repeat (50) @(negedge clk);

        // Update held high: captures at E0, E28, E56; Value changed at E0+5
        va = 24681357;
        vb = 13579;
        @(negedge clk);
        bus.Value  = 27'(va);
        bus.Update = 1'b1;
        for (int k = 0; k <= 83; k++) begin
            @(posedge clk);
            if (k == 0) sb.push_back(model(va));
            if (k == 28 || k == 56) sb.push_back(model(vb));
            @(negedge clk);
            if (k == 4) bus.Value = 27'(vb);
            if (k == 56) bus.Update = 1'b0;
            check_eq("held_busy", 64'(bus.Busy), 64'((k % 28) != 27));
        end
        repeat (22) @(negedge clk);

        // Clear mid-conversion aborts it
        @(negedge clk);
        bus.Value  = 27'd87654321;
        bus.Update = 1'b1;
        @(posedge clk);
        sb.push_back(model(87654321));
        @(negedge clk);
        bus.Update = 1'b0;
        repeat (9) @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        sb.delete();
        @(negedge clk);
        clear = 1'b0;
        check_eq("clr_busy", 64'(bus.Busy), 64'd0);
        check_eq("clr_done", 64'(bus.Done), 64'd0);
        check_eq("clr_ovf", 64'(bus.Overflow), 64'd0);
        check_eq("clr_anode", 64'(anode_n), 64'hFE);
        check_eq("clr_segs", 64'(seg_n), 64'hC0);
        convert(4096);
        repeat (10) @(negedge clk);

        check_eq("sb_empty_at_end", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/count_display_8digit.md
COUNT_DISPLAY_8DIGIT -- requirements
Module: count_display_8digit

Interface
REQ-001 Parameter SCAN_DIV, default 100000, gives the clock cycles each digit is driven (1 ms at 100 MHz), legal range 2..2^20.
REQ-002 Parameter BLANK_LEADING, default 1; 1 blanks leading zeros, 0 shows all eight digits.
REQ-003 Clock_100MHz  input  1  sole clock; all state changes on its rising edge.
REQ-004 Clear  input  1  reset, synchronous, active-high.
REQ-005 Value  input  27  binary value to display, nominal range 0..99999999.
REQ-006 Update  input  1  request to capture Value and convert it; sampled each edge.
REQ-007 Busy  output  1  conversion in progress; Update is ignored while high.
REQ-008 Done  output  1  one-cycle pulse when the new digits take effect.
REQ-009 Overflow  output  1  last captured Value exceeded 99999999; held until the next capture.
REQ-010 Anode_n  output  8  digit enables, active-low, one-hot-zero; bit 0 is the rightmost digit.
REQ-011 Segments_n  output  8  active-low cathodes {dp,g,f,e,d,c,b,a}, bits 7..0.

Function
REQ-012 Capture edge E0 is any edge with Update=1, Busy=0 and Clear=0; at E0 the block latches Value, sets Busy=1 and zeroes the iteration count.
REQ-013 Conversion shall be sequential double-dabble: one step per edge on E1..E27, with add-3 applied to every BCD nibble >=5 and then a 1-bit left shift into a 32-bit BCD register.
REQ-014 At E27 the block loads the display digit register, sets Busy=0 and drives Done=1 for exactly the following cycle.
REQ-015 Busy shall be high for exactly 27 cycles per conversion; an Update at E27 is ignored and the earliest next capture is E28.
REQ-016 Update while Busy=1 shall be dropped, not queued; Value changes after E0 have no effect on the result.
REQ-017 If the latched Value is greater than 99999999, then Overflow=1 from E0+1, timing is unchanged, and all eight digits show dash at E27.
REQ-018 If the latched Value is 99999999 or less, then Overflow=0 from E0+1.
REQ-019 The display digit register changes only at E27; the previous digits stay on display throughout a conversion.
REQ-020 The prescaler counts 0..SCAN_DIV-1 and then wraps; at each wrap the scan index advances 0->1->...->7->0.
REQ-021 Anode_n shall drive low only the bit at the scan index; all other bits are high.
REQ-022 Anode_n and Segments_n are registered from the scan index and digit register, one cycle behind the index.
REQ-023 Segments_n[6:0] encoding: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, dash=0111111, blank=1111111.
REQ-024 Segments_n[7] (dp) shall always be 1.
REQ-025 With BLANK_LEADING=1 and no overflow, digit i (i>=1) is blank when digits i..7 are all zero; digit 0 is never blanked.

Reset
REQ-026 Clear=1 at an edge sets Busy=0, Done=0, Overflow=0, all digits and the BCD register to 0, the iteration count to 0, the prescaler to 0 and the scan index to 0.
REQ-027 After that reset edge, Anode_n=11111110 and Segments_n=11000000 (digit 0 shows '0').
REQ-028 Clear has priority over Update and aborts any conversion in progress; the aborted result never reaches the display and Done does not pulse.
REQ-029 After Clear deasserts, Update is accepted at the first edge.

Verification
REQ-030 Update pulse with Value=12345678 -> Busy high 27 cycles, then one Done pulse; digits 7..0 = 1,2,3,4,5,6,7,8; Overflow=0.
REQ-031 Value=0 with BLANK_LEADING=1 -> only digit 0 shows 1000000, digits 1..7 blank; Value=00000305 -> digits 2..0 show 3,0,5, digits 7..3 blank.
REQ-032 Value=99999999, then Value=100000000 -> first all '9' (0010000) with Overflow=0; second Overflow=1 and all digits 0111111.
REQ-033 Update held high continuously -> captures at E0, E28, E56; Value changed at E0+5 is not reflected until the next capture.
REQ-034 Clear at E0+10 of a conversion of 87654321 -> next cycle Busy=0, no Done, display shows '0'; a fresh Update converts correctly.
REQ-035 SCAN_DIV=4 -> Anode_n steps 11111110, 11111101, ..., 01111111 every 4 cycles and wraps; exactly one bit is low at all times.
